// File: rtl/pairwise_gate_seq.sv
// pairwise_gate_seq: accepts a 4-bit operand word and emits three result beats.
// The beats are the AND, OR and XNOR of each adjacent bit pair of the word,
// in that order. The last beat (XNOR) is flagged with out_last.
// Optional feature: define PAIRWISE_GATE_SEQ_CNT_EN to add the words_done port,
// a saturating count of fully emitted words.
module pairwise_gate_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_,
    input  logic       in_val,
    output logic       in_rdy,
    output logic [2:0] out_data,
    output logic [1:0] out_op,
    output logic       out_last,
    output logic       out_val,
    input  logic       out_rdy
`ifdef PAIRWISE_GATE_SEQ_CNT_EN
    ,
    output logic [7:0] words_done
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_AND  = 2'd1,
        S_OR   = 2'd2,
        S_XNOR = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_word;
    logic       w_capture;
    logic       w_out_hs;

    // Bit k of each result combines word bits k and k+1.
    function automatic logic [2:0] pair_and(input logic [3:0] w);
        return w[2:0] & w[3:1];
    endfunction

    function automatic logic [2:0] pair_or(input logic [3:0] w);
        return w[2:0] | w[3:1];
    endfunction

    function automatic logic [2:0] pair_xnor(input logic [3:0] w);
        return ~(w[2:0] ^ w[3:1]);
    endfunction

    assign w_capture = in_val & in_rdy;
    assign w_out_hs  = out_val & out_rdy;

    // State register and captured operand word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_word  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_word <= in_;
            end
        end
    end

    // Next-state decode and beat outputs; outputs are all-zero when no beat is valid.
    always_comb begin
        w_next_state = r_state;
        in_rdy       = 1'b0;
        out_val      = 1'b0;
        out_op       = 2'd0;
        out_data     = 3'd0;
        out_last     = 1'b0;
        case (r_state)
            IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    w_next_state = S_AND;
                end
            end
            S_AND: begin
                out_val  = 1'b1;
                out_op   = 2'd0;
                out_data = pair_and(r_word);
                if (out_rdy) begin
                    w_next_state = S_OR;
                end
            end
            S_OR: begin
                out_val  = 1'b1;
                out_op   = 2'd1;
                out_data = pair_or(r_word);
                if (out_rdy) begin
                    w_next_state = S_XNOR;
                end
            end
            S_XNOR: begin
                out_val  = 1'b1;
                out_op   = 2'd2;
                out_data = pair_xnor(r_word);
                out_last = 1'b1;
                // A new word may be taken on the same edge the final beat leaves,
                // so back-to-back words stream with no idle cycle.
                in_rdy   = out_rdy;
                if (out_rdy) begin
                    w_next_state = in_val ? S_AND : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

`ifdef PAIRWISE_GATE_SEQ_CNT_EN
    logic [7:0] r_words_done;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Count words whose final beat has been accepted downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_words_done <= 8'd0;
        end else if (w_out_hs && out_last) begin
            r_words_done <= sat_inc8(r_words_done);
        end
    end

    assign words_done = r_words_done;
`else
    logic w_unused;
    assign w_unused = w_out_hs;
`endif

endmodule

// File: tb/tb_pairwise_gate_seq.sv
// Bench for pairwise_gate_seq: table-driven words with a beat scoreboard,
// plus hand-written stall, back-to-back, reset and (optional) counter sequences.
module tb_pairwise_gate_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_;
    logic       in_val;
    logic       in_rdy;
    logic [2:0] out_data;
    logic [1:0] out_op;
    logic       out_last;
    logic       out_val;
    logic       out_rdy;
`ifdef PAIRWISE_GATE_SEQ_CNT_EN
    logic [7:0] words_done;
`endif

    pairwise_gate_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_      (in_),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_op   (out_op),
        .out_last (out_last),
        .out_val  (out_val),
        .out_rdy  (out_rdy)
`ifdef PAIRWISE_GATE_SEQ_CNT_EN
        ,
        .words_done (words_done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] word;
        logic [2:0] e_and;
        logic [2:0] e_or;
        logic [2:0] e_xnor;
    } vec_t;

    vec_t       vecs[7];
    logic [5:0] exp_q[$];   // {op, data, last}
    int         tests;
    int         fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observe the DUT on the falling edge: pop/compare accepted beats, and
    // require all-zero beat outputs whenever no beat is valid.
    task automatic monitor_step();
        logic [5:0] e;
        if (rst_n) begin
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {26'd0, out_op, out_data, out_last}, 32'h3F);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {26'd0, out_op, out_data, out_last}, {26'd0, e});
                end
            end
            if (!out_val) begin
                chk("idle_zero", {26'd0, out_op, out_data, out_last}, 32'd0);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
    endtask

    // Offer a word; returns just after the accepting edge (AND beat on outputs).
    task automatic send(input logic [3:0] w, input logic [2:0] ea,
                        input logic [2:0] eo, input logic [2:0] ex);
        int n;
        in_    = w;
        in_val = 1'b1;
        n      = 0;
        while (!in_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!in_rdy) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back({2'd0, ea, 1'b0});
            exp_q.push_back({2'd1, eo, 1'b0});
            exp_q.push_back({2'd2, ex, 1'b1});
        end
        tick();
        in_val = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        vecs[0] = '{4'b1011, 3'b001, 3'b111, 3'b001};
        vecs[1] = '{4'b0000, 3'b000, 3'b000, 3'b111};
        vecs[2] = '{4'b1111, 3'b111, 3'b111, 3'b111};
        vecs[3] = '{4'b0110, 3'b010, 3'b111, 3'b010};
        vecs[4] = '{4'b1001, 3'b000, 3'b101, 3'b010};
        vecs[5] = '{4'b0101, 3'b000, 3'b111, 3'b000};
        vecs[6] = '{4'b1100, 3'b100, 3'b110, 3'b101};

        rst_n   = 1'b0;
        in_     = 4'd0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_out_val", out_val, 0);
        chk("rst_out_bus", {out_op, out_data, out_last}, 0);
`ifdef PAIRWISE_GATE_SEQ_CNT_EN
        chk("rst_words_done", words_done, 0);
`endif
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        tick();

        // Single word with exact beat timing, then back to idle.
        send(4'b1011, 3'b001, 3'b111, 3'b001);
        chk("w1011_and", {out_val, out_op, out_data, out_last}, {1'b1, 2'd0, 3'b001, 1'b0});
        chk("w1011_and_inrdy", in_rdy, 0);
        tick();
        chk("w1011_or", {out_val, out_op, out_data, out_last}, {1'b1, 2'd1, 3'b111, 1'b0});
        tick();
        chk("w1011_xnor", {out_val, out_op, out_data, out_last}, {1'b1, 2'd2, 3'b001, 1'b1});
        chk("w1011_xnor_inrdy", in_rdy, 1);
        tick();
        chk("w1011_idle_val", out_val, 0);
        chk("w1011_idle_rdy", in_rdy, 1);
        drain();

        // Table of words streamed back to back through the scoreboard.
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].word, vecs[i].e_and, vecs[i].e_or, vecs[i].e_xnor);
            chk("tbl_first_beat", {out_val, out_op, out_data}, {1'b1, 2'd0, vecs[i].e_and});
        end
        drain();

        // Downstream stall on the AND beat; input is ignored meanwhile.
        out_rdy = 1'b0;
        send(4'b0110, 3'b010, 3'b111, 3'b010);
        in_    = 4'b1001;
        in_val = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {out_val, out_op, out_data, out_last}, {1'b1, 2'd0, 3'b010, 1'b0});
            chk("stall_inrdy", in_rdy, 0);
            tick();
        end
        in_val  = 1'b0;
        out_rdy = 1'b1;
        tick();
        chk("stall_release_or", {out_val, out_op, out_data}, {1'b1, 2'd1, 3'b111});
        drain();
        tick();
        chk("stall_after_idle", {in_rdy, out_val}, 2'b10);

        // New word taken during the XNOR beat with no idle gap.
        send(4'b1011, 3'b001, 3'b111, 3'b001);
        send(4'b1111, 3'b111, 3'b111, 3'b111);
        chk("b2b_and", {out_val, out_op, out_data}, {1'b1, 2'd0, 3'b111});
        drain();

        // Reset during the OR beat discards the rest of the word.
        send(4'b1011, 3'b001, 3'b111, 3'b001);
        tick();
        chk("pre_rst_or", {out_val, out_op}, {1'b1, 2'd1});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        chk("post_rst", {in_rdy, out_val, out_op, out_data, out_last}, {1'b1, 1'b0, 2'd0, 3'd0, 1'b0});
`ifdef PAIRWISE_GATE_SEQ_CNT_EN
        chk("post_rst_words_done", words_done, 0);
`endif
        tick();
        chk("post_rst_idle", {in_rdy, out_val}, 2'b10);

`ifdef PAIRWISE_GATE_SEQ_CNT_EN
        // Saturating word counter.
        send(4'b0000, 3'b000, 3'b000, 3'b111);
        drain();
        chk("cnt_one", words_done, 1);
        for (int i = 1; i < 300; i++) begin
            send(4'b1011, 3'b001, 3'b111, 3'b001);
        end
        drain();
        chk("cnt_sat", words_done, 255);
        for (int i = 0; i < 3; i++) begin
            send(4'b1111, 3'b111, 3'b111, 3'b111);
        end
        drain();
        chk("cnt_sat_hold", words_done, 255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
